// File: rtl/cpu_ram_block_pkg.sv
// Shared constants and small helpers for the cpu_ram_block memory slice.
package cpu_ram_block_pkg;

    localparam int BYTE_W = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = BYTE_W * LANES;

    // A request with no byte strobes set is a read of the whole word.
    function automatic logic is_read(input logic [LANES-1:0] strb);
        return (strb == 4'b0000);
    endfunction

endpackage

// File: rtl/cpu_ram_block_if.sv
// Native CPU memory bus: valid/ready handshake with byte strobes.
interface cpu_ram_block_if #(
    parameter int SIZE = 13
);
    import cpu_ram_block_pkg::*;

    logic [SIZE+1:0]   addr;
    logic [WORD_W-1:0] wdata;
    logic [LANES-1:0]  wstrb;
    logic              valid;
    logic [WORD_W-1:0] rdata;
    logic              ready;

    modport master (
        output addr,
        output wdata,
        output wstrb,
        output valid,
        input  rdata,
        input  ready
    );

    modport slave (
        input  addr,
        input  wdata,
        input  wstrb,
        input  valid,
        output rdata,
        output ready
    );

endinterface

// File: rtl/cpu_ram_lane.sv
// One byte lane: 8-bit x 2^SIZE single-port synchronous RAM with registered read.
module cpu_ram_lane
    import cpu_ram_block_pkg::*;
#(
    parameter int SIZE = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [SIZE-1:0]   addr,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout
);

    // Array storage is deliberately not reset so it maps onto block RAM.
    logic [BYTE_W-1:0] mem_r [0:(1<<SIZE)-1];
    logic [BYTE_W-1:0] dout_r;

    // Array write port: commits on the edge the request is accepted.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
    end

    // Registered read port: only reads update it, so the last read word holds.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_r <= 8'h00;
        end else if (re) begin
            dout_r <= mem_r[addr];
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;

endmodule

// File: rtl/cpu_ram_block.sv
// Byte-writable 32-bit word RAM on the CPU native bus; one-cycle ready pulse.
module cpu_ram_block
    import cpu_ram_block_pkg::*;
#(
    parameter int SIZE = 13
) (
    input  logic              clk,
    input  logic              reset,
    cpu_ram_block_if.slave    bus
);

    logic            ready_r;
    logic            accept_s;
    logic            read_s;
    logic [SIZE-1:0] word_s;
    logic            unused_s;

    // The only pending state is the ready cycle itself, so ready_r doubles as
    // the busy flag. Request fields are captured by the lane address/data
    // registers on the acceptance edge, so later bus changes cannot disturb it.
    assign accept_s = reset & bus.valid & ~ready_r;
    assign read_s   = is_read(bus.wstrb);
    assign word_s   = bus.addr[SIZE+1:2];
    assign unused_s = ^bus.addr[1:0];

    // Completion pulse: high for exactly the cycle after each acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= accept_s;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cpu_ram_lane #(
            .SIZE (SIZE)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .we    (accept_s & bus.wstrb[i]),
            .re    (accept_s & read_s),
            .addr  (word_s),
            .din   (bus.wdata[i*BYTE_W +: BYTE_W]),
            .dout  (bus.rdata[i*BYTE_W +: BYTE_W])
        );
    end

    assign bus.ready = ready_r;

endmodule

// File: tb/tb_cpu_ram_block.sv
// Self-checking bench for cpu_ram_block against a word-array reference model.
module tb_cpu_ram_block;

    localparam int SIZE = 13;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    // Reference model: words indexed by word address, plus last read word.
    logic [31:0] mem_m [int];
    logic [31:0] exp_rdata;

    cpu_ram_block_if #(.SIZE(SIZE)) bus ();

    cpu_ram_block #(
        .SIZE (SIZE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Apply the reference model's view of one accepted request.
    task automatic model_apply(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        int          k;
        logic [31:0] w;
        k = int'(a[14:2]);
        if (s == 4'b0000) begin
            exp_rdata = mem_m[k];
        end else begin
            w = mem_m.exists(k) ? mem_m[k] : 32'h0000_0000;
            for (int i = 0; i < 4; i++) begin
                if (s[i]) w[i*8 +: 8] = d[i*8 +: 8];
            end
            mem_m[k] = w;
        end
    endtask

    // One single-cycle valid pulse; bus fields go X right after acceptance.
    task automatic do_req(input string name, input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.addr  = a;
        bus.wdata = d;
        bus.wstrb = s;
        bus.valid = 1'b1;
        @(negedge clk);
        model_apply(a, d, s);
        bus.valid = 1'b0;
        bus.addr  = 'x;
        bus.wdata = 'x;
        bus.wstrb = 'x;
        vectors++;
        if (bus.ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready: got %b want 1 (addr %h)", name, bus.ready, a);
        end
        vectors++;
        if (bus.rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL %s rdata: got %h want %h (addr %h strb %b)", name, bus.rdata, exp_rdata, a, s);
        end
        @(negedge clk);
        vectors++;
        if (bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s ready_pulse_width: got %b want 0", name, bus.ready);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        bus.valid = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        exp_rdata = 32'h0000_0000;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", bus.ready);
        end
        vectors++;
        if (bus.rdata !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h want 00000000", bus.rdata);
        end
        reset = 1'b1;
    endtask

    task automatic test_word_writes();
        logic [31:0] pat [5];
        pat = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'h0F1E2D3C, 32'hA5A55A5A};
        for (int w = 4; w >= 0; w--) do_req("word_wr", 15'(w * 4), pat[w], 4'b1111);
        for (int w = 0; w < 5; w++) do_req("word_rd", 15'(w * 4), 32'h0, 4'b0000);
    endtask

    task automatic test_halfword_merge();
        for (int w = 0; w < 5; w++) begin
            do_req("half_lo", 15'(w * 4), 32'h11112222, 4'b0011);
            do_req("half_hi", 15'(w * 4), 32'h33334444, 4'b1100);
        end
        for (int w = 0; w < 5; w++) begin
            do_req("half_rd", 15'(w * 4), 32'h0, 4'b0000);
            vectors++;
            if (bus.rdata !== 32'h33332222) begin
                miscompares++;
                $display("FAIL half_value: got %h want 33332222 (word %0d)", bus.rdata, w);
            end
        end
    endtask

    task automatic test_byte_merge();
        logic [31:0] bd [4];
        bd = '{32'h000000AA, 32'h0000BB00, 32'h00CC0000, 32'hDD000000};
        for (int b = 0; b < 4; b++) begin
            if (b % 2 == 0) begin
                for (int w = 0; w < 5; w++) do_req("byte_wr_up", 15'(w * 4), bd[b], 4'(1 << b));
            end else begin
                for (int w = 4; w >= 0; w--) do_req("byte_wr_dn", 15'(w * 4), bd[b], 4'(1 << b));
            end
        end
        for (int w = 4; w >= 0; w--) begin
            do_req("byte_rd", 15'(w * 4), 32'h0, 4'b0000);
            vectors++;
            if (bus.rdata !== 32'hDDCCBBAA) begin
                miscompares++;
                $display("FAIL byte_value: got %h want DDCCBBAA (word %0d)", bus.rdata, w);
            end
        end
    endtask

    task automatic test_handshake();
        int ready_count;
        do_req("hs_wr", 15'h0008, 32'h5EED1234, 4'b1111);
        // Hold valid through the ready cycle, then drop it.
        @(negedge clk);
        bus.addr  = 15'h0008;
        bus.wdata = 32'h0;
        bus.wstrb = 4'b0000;
        bus.valid = 1'b1;
        ready_count = 0;
        @(negedge clk);
        model_apply(15'h0008, 32'h0, 4'b0000);
        if (bus.ready === 1'b1) ready_count++;
        vectors++;
        if (bus.rdata !== exp_rdata) begin
            miscompares++;
            $display("FAIL hold_rdata: got %h want %h", bus.rdata, exp_rdata);
        end
        @(negedge clk);
        bus.valid = 1'b0;
        bus.addr  = 'x;
        bus.wstrb = 'x;
        bus.wdata = 'x;
        if (bus.ready === 1'b1) ready_count++;
        repeat (3) begin
            @(negedge clk);
            if (bus.ready === 1'b1) ready_count++;
        end
        vectors++;
        if (ready_count != 1) begin
            miscompares++;
            $display("FAIL hold_ready_count: got %0d want 1", ready_count);
        end
    endtask

    task automatic test_reset_protect();
        int ready_seen;
        do_req("rst_pre_wr", 15'h000C, 32'hC0FFEE11, 4'b1111);
        ready_seen = 0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.addr  = 15'h000C;
            bus.wdata = 32'hBAD0BAD0;
            bus.wstrb = 4'b1111;
            bus.valid = (c % 2 == 0);
            @(negedge clk);
            if (bus.ready !== 1'b0) ready_seen++;
        end
        bus.valid = 1'b0;
        reset     = 1'b1;
        exp_rdata = 32'h0000_0000;
        vectors++;
        if (ready_seen != 0) begin
            miscompares++;
            $display("FAIL rst_ready_during_reset: got %0d pulses want 0", ready_seen);
        end
        vectors++;
        if (bus.rdata !== 32'h0000_0000) begin
            miscompares++;
            $display("FAIL rst_rdata_cleared: got %h want 00000000", bus.rdata);
        end
        do_req("rst_post_rd", 15'h000C, 32'h0, 4'b0000);
    endtask

    task automatic test_addr_edges();
        do_req("edge_hi_wr", 15'h7FFC, 32'hFEEDF00D, 4'b1111);
        do_req("edge_lo_wr", 15'h0001, 32'h600DCAFE, 4'b1111);
        do_req("edge_hi_rd", 15'h7FFF, 32'h0, 4'b0000);
        vectors++;
        if (bus.rdata !== 32'hFEEDF00D) begin
            miscompares++;
            $display("FAIL edge_hi_value: got %h want FEEDF00D", bus.rdata);
        end
        do_req("edge_lo_rd", 15'h0002, 32'h0, 4'b0000);
        vectors++;
        if (bus.rdata !== 32'h600DCAFE) begin
            miscompares++;
            $display("FAIL edge_lo_value: got %h want 600DCAFE", bus.rdata);
        end
    endtask

    task automatic test_random();
        int          words [6];
        int          w;
        logic [14:0] a;
        words = '{0, 1, 2, 3, 4, 8191};
        for (int n = 0; n < 200; n++) begin
            w = words[$urandom_range(0, 5)];
            a = 15'(w * 4 + int'($urandom_range(0, 3)));
            do_req("random", a, 32'($urandom), 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_word_writes();
        test_halfword_merge();
        test_byte_merge();
        test_handshake();
        test_reset_protect();
        test_addr_edges();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
